// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - signed 16-bit product to sign + 5-digit BCD (double dabble)
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module product_bcd_converter (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  Aval,
   input  logic [7:0]  Bval,
   output logic        Neg,
   output logic [19:0] Digits,
   output logic [4:0]  Blank,
   output logic        Busy,
   output logic        Done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [15:0] product;
   logic [15:0] magnitude_in;
   logic [15:0] magnitude;
   logic [19:0] scratch;
   logic [19:0] scratch_adj;
   logic [3:0]  count;
   logic        sign;

   assign product      = {Aval, Bval};
   // Negating 16'h8000 yields 16'h8000, which read unsigned is exactly 32768.
   assign magnitude_in = product[15] ? (~product + 16'd1) : product;

   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < 5; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      Busy       = 1'b0;
      case (state)
         IDLE: begin
            if (Start)
               next_state = SHIFT;
         end
         SHIFT: begin
            Busy = 1'b1;
            if (count == 4'd15)
               next_state = FINISH;
         end
         FINISH: begin
            Busy       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         magnitude <= 16'd0;
         scratch   <= 20'd0;
         count     <= 4'd0;
         sign      <= 1'b0;
         Neg       <= 1'b0;
         Digits    <= 20'd0;
         Done      <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  magnitude <= magnitude_in;
                  sign      <= product[15];
                  scratch   <= 20'd0;
                  count     <= 4'd0;
               end
            end
            SHIFT: begin
               {scratch, magnitude} <= {scratch_adj[18:0], magnitude, 1'b0};
               count                <= count + 4'd1;
            end
            FINISH: begin
               Digits <= scratch;
               Neg    <= sign;
               Done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         Blank <= 5'b11110;
      end else if (state == FINISH) begin
         Blank[4] <= (scratch[19:16] == 4'd0);
         Blank[3] <= (scratch[19:12] == 8'd0);
         Blank[2] <= (scratch[19:8] == 12'd0);
         Blank[1] <= (scratch[19:4] == 16'd0);
         Blank[0] <= 1'b0;
      end
   end
`else
   assign Blank = 5'b00000;
`endif

endmodule
